ibex_bp_fetch_ctrl: RTL

Fetch sequencer sitting between the instruction bus, the branch predictor and the ID stage. Issues one instruction-bus request at a time and presents each returned instruction plus its PC to the predictor. Picks the next fetch PC (predicted target or sequential), holds the result in a one-entry output register for ID, and handles redirects from the controller by discarding in-flight responses.

---
 rtl/ibex_bp_fetch_pkg.sv | 20 ++
 rtl/ibex_bp_fetch_ctrl_sat_counter.sv | 20 ++
 rtl/ibex_bp_fetch_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_bp_fetch_pkg.sv
// Shared types, constants and helpers for the branch-predicting fetch sequencer.
package ibex_bp_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } fetch_state_e;

    localparam int unsigned INSTR_LEN_32 = 4;
    localparam int unsigned INSTR_LEN_16 = 2;

    // Byte length of an instruction from its two low opcode bits.
    function automatic logic [31:0] instr_len(input logic [1:0] rdata_lo);
        return (rdata_lo == 2'b11) ? 32'(INSTR_LEN_32) : 32'(INSTR_LEN_16);
    endfunction

endpackage

// File: rtl/ibex_bp_fetch_ctrl_sat_counter.sv
// Saturating up-counter used for the optional fetch performance counters.
module ibex_bp_sat_counter #(
    parameter int unsigned CntW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    output logic [CntW-1:0] count_o
);

    // Count up on each enabled cycle, sticking at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_i && !(&count_o)) begin
            count_o <= count_o + CntW'(1);
        end
    end

endmodule

// File: rtl/ibex_bp_fetch_ctrl.sv
// Fetch sequencer between instruction bus, branch predictor and ID stage.
// Optional performance counters are built when IBEX_BP_PERF_CNT_EN is defined.
module ibex_bp_fetch_ctrl
    import ibex_bp_fetch_pkg::*;
#(
    parameter bit          BpEnable = 1'b1,
    parameter int unsigned CntW     = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     boot_addr_i,
    input  logic            fetch_enable_i,
    output logic            instr_req_o,
    output logic [31:0]     instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [31:0]     instr_rdata_i,
    input  logic            instr_err_i,
    output logic            bp_valid_o,
    output logic [31:0]     bp_rdata_o,
    output logic [31:0]     bp_pc_o,
    input  logic            bp_taken_i,
    input  logic [31:0]     bp_target_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_rdata_o,
    output logic [31:0]     id_pc_o,
    output logic            id_pred_taken_o,
    output logic            id_err_o,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_pc_i,
    output logic [CntW-1:0] perf_pred_taken_o,
    output logic [CntW-1:0] perf_redirect_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_addr_q;
    logic         discard_q, discard_d;
    logic         err_stop_q, err_stop_d;
    logic         rsp_accept_c;
    logic         taken_c;
    logic         id_free_c;
    logic         req_load_c;

    // The output register can take a new fetch once empty or being drained.
    assign id_free_c = !id_valid_o || id_ready_i;
    assign taken_c   = BpEnable && bp_taken_i && !instr_err_i;

    // Latch the request address whenever a fresh request starts.
    assign req_load_c = (state_q != REQ) && (state_d != state_q) &&
                        ((state_d == REQ) || (state_d == WAIT));

    // State and fetch-PC registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= {boot_addr_i[31:1], 1'b0};
            req_addr_q <= '0;
            discard_q  <= 1'b0;
            err_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            err_stop_q <= err_stop_d;
            if (req_load_c) begin
                req_addr_q <= fetch_pc_d;
            end
        end
    end

    // Next-state, next-PC and bus/predictor outputs.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        discard_d    = discard_q;
        err_stop_d   = err_stop_q;
        rsp_accept_c = 1'b0;
        instr_req_o  = 1'b0;
        instr_addr_o = '0;
        bp_valid_o   = 1'b0;
        bp_rdata_o   = '0;
        bp_pc_o      = '0;

        unique case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    state_d = fetch_enable_i ? REQ : IDLE;
                end else if (fetch_enable_i && !err_stop_q && id_free_c) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                instr_req_o  = 1'b1;
                instr_addr_o = req_addr_q;
                if (redirect_i) begin
                    discard_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    state_d = (discard_q || redirect_i) ? FLUSH : WAIT;
                end
            end
            WAIT: begin
                if (instr_rvalid_i) begin
                    if (redirect_i) begin
                        state_d = fetch_enable_i ? REQ : IDLE;
                    end else begin
                        bp_valid_o   = 1'b1;
                        bp_rdata_o   = instr_rdata_i;
                        bp_pc_o      = req_addr_q;
                        rsp_accept_c = 1'b1;
                        fetch_pc_d   = taken_c ? {bp_target_i[31:1], 1'b0}
                                               : req_addr_q + instr_len(instr_rdata_i[1:0]);
                        if (instr_err_i) begin
                            state_d    = IDLE;
                            err_stop_d = 1'b1;
                        end else begin
                            state_d = fetch_enable_i ? HOLD : IDLE;
                        end
                    end
                end else if (redirect_i) begin
                    state_d = FLUSH;
                end
            end
            HOLD: begin
                // Issue the next request in the same cycle ID drains the register.
                if (redirect_i) begin
                    state_d = fetch_enable_i ? REQ : IDLE;
                end else if (!fetch_enable_i) begin
                    state_d = IDLE;
                end else if (id_free_c) begin
                    instr_req_o  = 1'b1;
                    instr_addr_o = fetch_pc_q;
                    state_d      = instr_gnt_i ? WAIT : REQ;
                end
            end
            FLUSH: begin
                if (instr_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = fetch_enable_i ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:1], 1'b0};
            err_stop_d = 1'b0;
        end
    end

    // One-entry output register towards ID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_valid_o      <= 1'b0;
            id_rdata_o      <= '0;
            id_pc_o         <= '0;
            id_pred_taken_o <= 1'b0;
            id_err_o        <= 1'b0;
        end else if (rsp_accept_c) begin
            id_valid_o      <= 1'b1;
            id_rdata_o      <= instr_rdata_i;
            id_pc_o         <= req_addr_q;
            id_pred_taken_o <= taken_c;
            id_err_o        <= instr_err_i;
        end else if (redirect_i || id_ready_i) begin
            id_valid_o <= 1'b0;
        end
    end

`ifdef IBEX_BP_PERF_CNT_EN
    logic pred_inc_c;
    assign pred_inc_c = rsp_accept_c && taken_c;

    ibex_bp_sat_counter #(.CntW(CntW)) u_cnt_pred_taken (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (pred_inc_c),
        .count_o (perf_pred_taken_o)
    );

    ibex_bp_sat_counter #(.CntW(CntW)) u_cnt_redirect (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (redirect_i),
        .count_o (perf_redirect_o)
    );
`else
    assign perf_pred_taken_o = '0;
    assign perf_redirect_o   = '0;
`endif

endmodule
